// File: rtl/vec_mem_sequencer_if.sv
// Request, data-memory and writeback bundle between the pipeline and the
// vector memory sequencer.
interface vec_mem_sequencer_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_store;
  logic                    req_vector;
  logic [ADDR_W-1:0]       req_addr;
  logic [LANES*DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]        req_reg;
  logic                    stall;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    wb_valid;
  logic                    wb_vector;
  logic [REG_W-1:0]        wb_reg;
  logic [LANES*DATA_W-1:0] wb_data;
  logic                    done;

  modport master (
    output req_valid, req_store, req_vector, req_addr, req_wdata, req_reg,
    output mem_rdata,
    input  req_ready, stall, mem_addr, mem_re, mem_we, mem_wdata,
    input  wb_valid, wb_vector, wb_reg, wb_data, done
  );

  modport slave (
    input  req_valid, req_store, req_vector, req_addr, req_wdata, req_reg,
    input  mem_rdata,
    output req_ready, stall, mem_addr, mem_re, mem_we, mem_wdata,
    output wb_valid, wb_vector, wb_reg, wb_data, done
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Multi-cycle scalar/vector load-store sequencer for the single-port data
// memory: one lane access per cycle, loads assembled into one writeback.
module vec_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4
) (
  input logic                clk,
  input logic                rst_n,
  vec_mem_sequencer_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, WB} state_e;

  state_e                       state_q, state_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [LW-1:0]                rd_lane_q, rd_lane_d;
  logic                         rd_pend_q, rd_pend_d;
  logic                         store_q, store_d;
  logic                         vector_q, vector_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [REG_W-1:0]             reg_q, reg_d;
  logic [LANES-1:0][DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0][DATA_W-1:0] wb_data_q, wb_data_d;
  logic [LW-1:0]                last_lane;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    rd_lane_d = rd_lane_q;
    rd_pend_d = 1'b0;
    store_d   = store_q;
    vector_d  = vector_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    last_lane = vector_q ? LW'(LANES - 1) : '0;

    bus.req_ready = 1'b0;
    bus.stall     = (state_q != IDLE);
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_vector = 1'b0;
    bus.wb_reg    = '0;
    bus.wb_data   = wb_data_q;
    bus.done      = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          vector_d = bus.req_vector;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          reg_d    = bus.req_reg;
          lane_d   = '0;
          state_d  = ACCESS;
          if (!bus.req_store) wb_data_d = '0;
        end
      end
      ACCESS: begin
        bus.mem_addr = addr_q + ADDR_W'(lane_q);
        if (store_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = wdata_q[lane_q];
        end else begin
          bus.mem_re = 1'b1;
          rd_pend_d  = 1'b1;
          rd_lane_d  = lane_q;
        end
        if (lane_q == last_lane) begin
          if (store_q) begin
            bus.done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      DRAIN: state_d = WB;
      WB: begin
        bus.wb_valid  = 1'b1;
        bus.wb_vector = vector_q;
        bus.wb_reg    = reg_q;
        bus.done      = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Read data lags mem_re by one cycle, so capture uses the lane latched with it.
    if (rd_pend_q) wb_data_d[rd_lane_q] = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      rd_lane_q <= '0;
      rd_pend_q <= 1'b0;
      store_q   <= 1'b0;
      vector_q  <= 1'b0;
      addr_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      rd_lane_q <= rd_lane_d;
      rd_pend_q <= rd_pend_d;
      store_q   <= store_d;
      vector_q  <= vector_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
    end
  end
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: stimulus queues expected memory,
// writeback and busy-length events; a negedge monitor pops and compares.
module tb_vec_mem_sequencer;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  vec_mem_sequencer_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    logic        vector;
    logic [3:0]  rg;
    logic [63:0] data;
  } wb_t;

  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  wb_t         wb_q[$];
  int          stall_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d, input logic l);
    wr_t w;
    w.addr = a; w.data = d; w.last = l;
    wr_q.push_back(w);
  endtask

  task automatic exp_wb(input logic v, input logic [3:0] r, input logic [63:0] d);
    wb_t w;
    w.vector = v; w.rg = r; w.data = d;
    wb_q.push_back(w);
  endtask

  // Memory model: registered read, 0xBEEF at word 5, otherwise 0xA000 + addr.
  always @(posedge clk) begin
    if (bus.mem_re)
      bus.mem_rdata <= (bus.mem_addr == 16'h0005) ? 16'hBEEF : 16'hA000 + bus.mem_addr;
    else
      bus.mem_rdata <= 16'h0000;
  end

  int run = 0;
  always @(negedge clk) begin
    wr_t  w;
    wb_t  b;
    logic done_exp;
    if (!rst_n) begin
      run = 0;
    end else begin
      done_exp = 1'b0;
      chk("strobe_excl", {63'd0, bus.mem_re & bus.mem_we}, 64'd0);
      chk("stall_vs_ready", {63'd0, bus.stall}, {63'd0, !bus.req_ready});
      if (!bus.mem_re && !bus.mem_we) chk("idle_addr", {48'd0, bus.mem_addr}, 64'd0);
      if (bus.mem_we) begin
        if (wr_q.size() == 0) fail_evt("unexpected_write");
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", {48'd0, bus.mem_addr}, {48'd0, w.addr});
          chk("wr_data", {48'd0, bus.mem_wdata}, {48'd0, w.data});
          done_exp = w.last;
        end
      end
      if (bus.mem_re) begin
        if (rd_q.size() == 0) fail_evt("unexpected_read");
        else chk("rd_addr", {48'd0, bus.mem_addr}, {48'd0, rd_q.pop_front()});
      end
      if (bus.wb_valid) begin
        if (wb_q.size() == 0) fail_evt("unexpected_wb");
        else begin
          b = wb_q.pop_front();
          chk("wb_vector", {63'd0, bus.wb_vector}, {63'd0, b.vector});
          chk("wb_reg", {60'd0, bus.wb_reg}, {60'd0, b.rg});
          chk("wb_data", bus.wb_data, b.data);
        end
        done_exp = 1'b1;
      end
      chk("done", {63'd0, bus.done}, {63'd0, done_exp});
      if (bus.stall) begin
        run++;
      end else if (run > 0) begin
        if (stall_q.size() == 0) fail_evt("unexpected_busy");
        else chk("stall_cycles", 64'(run), 64'(stall_q.pop_front()));
        run = 0;
      end
    end
  end

  task automatic issue(input logic st, input logic vec, input logic [15:0] a,
                       input logic [63:0] wd, input logic [3:0] rg);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_vector = vec;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_reg    = rg;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_evt("accept_timeout");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'hDEAD;
    bus.req_wdata = '1;
    bus.req_reg   = 4'hF;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.stall || stall_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_evt("idle_timeout");
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_vector = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_reg    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_strobes", {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
    chk("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Vector store at 0x0010
    exp_wr(16'h0010, 16'h1111, 1'b0);
    exp_wr(16'h0011, 16'h2222, 1'b0);
    exp_wr(16'h0012, 16'h3333, 1'b0);
    exp_wr(16'h0013, 16'h4444, 1'b1);
    stall_q.push_back(4);
    issue(1'b1, 1'b1, 16'h0010, 64'h4444_3333_2222_1111, 4'h0);

    // Vector load at 0x0020, then a scalar load held while busy
    rd_q.push_back(16'h0020); rd_q.push_back(16'h0021);
    rd_q.push_back(16'h0022); rd_q.push_back(16'h0023);
    exp_wb(1'b1, 4'h9, 64'hA023_A022_A021_A020);
    stall_q.push_back(6);
    issue(1'b0, 1'b1, 16'h0020, 64'h0, 4'h9);
    rd_q.push_back(16'h0030);
    exp_wb(1'b0, 4'h7, 64'h0000_0000_0000_A030);
    stall_q.push_back(3);
    issue(1'b0, 1'b0, 16'h0030, 64'h0, 4'h7);

    // Scalar load at 0x0005
    rd_q.push_back(16'h0005);
    exp_wb(1'b0, 4'h3, 64'h0000_0000_0000_BEEF);
    stall_q.push_back(3);
    issue(1'b0, 1'b0, 16'h0005, 64'h0, 4'h3);

    // Wrapping vector store at 0xFFFE
    exp_wr(16'hFFFE, 16'h0A01, 1'b0);
    exp_wr(16'hFFFF, 16'h0B02, 1'b0);
    exp_wr(16'h0000, 16'h0C03, 1'b0);
    exp_wr(16'h0001, 16'h0D04, 1'b1);
    stall_q.push_back(4);
    issue(1'b1, 1'b1, 16'hFFFE, 64'h0D04_0C03_0B02_0A01, 4'h0);
    wait_idle();
    chk("wb_data_hold", bus.wb_data, 64'h0000_0000_0000_BEEF);

    // Vector load at 0x0050 aborted by reset during lane 2
    rd_q.push_back(16'h0050); rd_q.push_back(16'h0051); rd_q.push_back(16'h0052);
    issue(1'b0, 1'b1, 16'h0050, 64'h0, 4'h2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_re", {63'd0, bus.mem_re}, 64'd0);
    chk("abort_stall", {63'd0, bus.stall}, 64'd0);
    chk("abort_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("abort_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("abort_addr", {48'd0, bus.mem_addr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Fresh scalar store after reset
    exp_wr(16'h0077, 16'h5A5A, 1'b1);
    stall_q.push_back(1);
    issue(1'b1, 1'b0, 16'h0077, 64'hFFFF_FFFF_FFFF_5A5A, 4'h0);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    chk("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    chk("stall_queue_empty", 64'(stall_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Multi-cycle controller that sits between the decode/execute stages and the single-port data memory of the SIMD core.
- Accepts one memory request per operation: scalar or vector, load or store.
- Issues one memory lane access per cycle and stalls the pipeline while busy.
- For loads, assembles the lane data into a single register writeback.

Parameters:
LANES, 4, number of 16-bit lanes in a vector register
DATA_W, 16, lane/scalar data width in bits
ADDR_W, 16, data memory word-address width
REG_W, 4, register index width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  memory request present
req_ready  output  1  sequencer can accept a request (state IDLE)
req_store  input  1  1 = store, 0 = load
req_vector  input  1  1 = LANES-lane access, 0 = single-lane scalar access
req_addr  input  ADDR_W  base word address
req_wdata  input  LANES*DATA_W  store data, lane k at bits [k*DATA_W +: DATA_W]
req_reg  input  REG_W  destination register for loads
stall  output  1  high whenever state != IDLE; freezes PC and front-end stages
mem_addr  output  ADDR_W  memory word address
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_re
wb_valid  output  1  one-cycle writeback pulse
wb_vector  output  1  writeback targets vector register file (0 = scalar)
wb_reg  output  REG_W  writeback register index
wb_data  output  LANES*DATA_W  assembled load data
done  output  1  one-cycle pulse at completion of any request

Behaviour:
- Reset (async, rst_n=0): state IDLE, lane counter 0.
  - All outputs 0, except req_ready=1.
  - Captured request registers and wb_data cleared.
  - Reset mid-operation aborts immediately: mem_we/mem_re drop without waiting for clk; no wb_valid or done.
- States: IDLE, ACCESS, DRAIN, WB.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge, capture store, vector, addr, wdata and reg; clear lane counter; go to ACCESS.
  - Requests while not IDLE are ignored; the requester holds req_valid until accepted.
- ACCESS, lane counter k:
  - mem_addr = base + k, modulo 2^ADDR_W (wraps; no error).
  - Store: mem_we=1, mem_wdata = captured lane k.
  - Load: mem_re=1.
  - Last lane = LANES-1 for vector, 0 for scalar.
  - Not last lane: k increments, stay in ACCESS.
  - Last lane, store: go to IDLE with done=1 in that ACCESS cycle.
  - Last lane, load: go to DRAIN.
- Load data capture: mem_rdata sampled the cycle after each mem_re into lane k of wb_data.
  - Lanes 0..last-1 are captured during ACCESS; the last lane is captured during DRAIN.
  - Scalar load: lane 0 only; other lanes 0.
- DRAIN: no memory strobes; capture last lane; go to WB.
- WB:
  - wb_valid=1, done=1.
  - wb_reg = captured reg; wb_vector = captured vector; wb_data stable.
  - Go to IDLE next edge.
  - wb_data holds its value until the next load is accepted.
- Latency, counted from the acceptance edge:
  - Vector store: LANES cycles busy.
  - Scalar store: 1 cycle busy.
  - Vector load: LANES+2 cycles busy.
  - Scalar load: 3 cycles busy.
- stall = (state != IDLE); stall and req_ready are complements.
- mem_re and mem_we are never both 1; mem_addr=0 when neither strobe is active.
- Back-to-back: a request held at the edge that returns to IDLE is accepted one cycle later (1 idle cycle minimum between operations).

Test Plan:
- Vector store: addr=0x0010, wdata lanes {0x1111,0x2222,0x3333,0x4444} -> mem_we on 4 consecutive cycles, addrs 0x10..0x13, matching data; done pulses with the 4th write; stall high exactly 4 cycles.
- Vector load: addr=0x0020, memory model returns 0xA000+addr -> wb_valid once, wb_data lanes {0xA020,0xA021,0xA022,0xA023}, wb_vector=1, wb_reg=req_reg; stall high 6 cycles.
- Scalar load: addr=0x0005, reg=3, mem returns 0xBEEF -> one mem_re; wb_data = {0,0,0,0xBEEF}, wb_vector=0, wb_reg=3; stall 3 cycles.
- Address wrap: vector store at addr=0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Busy rejection: second req_valid asserted during a vector load with different addr -> ignored until req_ready=1, then executes correctly; no strobe overlap between the two operations.
- Reset mid-load: rst_n low asynchronously during lane 2 -> mem_re, stall, wb_valid go 0 immediately, req_ready=1; after release, a fresh scalar store completes normally.
